fetch_seq: RTL and testbench

//   Instruction fetch sequencer; drives the 8-bit program counter's load/inc

---
 rtl/fetch_seq.sv | 117 +++++++++++
 tb/tb_fetch_seq.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer driving PC inc/load and program memory reads
module fetch_seq #(
  parameter int             AW      = 8,
  parameter int             DW      = 8,
  parameter logic [DW-1:0]  JMP_OP  = 8'h40,
  parameter logic [DW-1:0]  HALT_OP = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] pc_addr,
  output logic          pc_inc,
  output logic          pc_load,
  output logic [AW-1:0] pc_target,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          ins_valid,
  input  logic          ins_ready,
  output logic [DW-1:0] ins_data,
  output logic          halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_ISSUE,
    S_OPERAND,
    S_HALTED
  } state_t;

  state_t        state;
  logic [DW-1:0] ir;

  // Sequencer state and registered handshake outputs; mem_req/ins_valid/halted
  // are set on the transition into the state that owns them so they are valid
  // for the whole residency in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      ins_valid <= 1'b0;
      ins_data  <= '0;
      halted    <= 1'b0;
      ir        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_FETCH;
            mem_req <= 1'b1;
          end
        end
        S_FETCH: begin
          if (mem_ready) begin
            ir      <= mem_rdata;
            mem_req <= 1'b0;
            state   <= S_DECODE;
          end
        end
        S_DECODE: begin
          // HALT takes priority so a HALT encoding can never be mistaken for a jump
          if (ir == HALT_OP) begin
            halted <= 1'b1;
            state  <= S_HALTED;
          end else if (ir == JMP_OP) begin
            mem_req <= 1'b1;
            state   <= S_OPERAND;
          end else begin
            ins_valid <= 1'b1;
            ins_data  <= ir;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (ins_ready) begin
            ins_valid <= 1'b0;
            mem_req   <= 1'b1;
            state     <= S_FETCH;
          end
        end
        S_OPERAND: begin
          // Operand read completes straight into the next fetch at the target,
          // so mem_req stays asserted across the transition.
          if (mem_ready) begin
            state <= S_FETCH;
          end
        end
        S_HALTED: begin
          if (start) begin
            halted  <= 1'b0;
            mem_req <= 1'b1;
            state   <= S_FETCH;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_req   <= 1'b0;
          ins_valid <= 1'b0;
          halted    <= 1'b0;
        end
      endcase
    end
  end

  // PC controls must act in the same cycle the memory completes, so they are
  // decoded from state and mem_ready rather than registered.
  always_comb begin
    pc_inc    = (state == S_FETCH)   && mem_ready;
    pc_load   = (state == S_OPERAND) && mem_ready;
    pc_target = pc_load ? AW'(mem_rdata) : '0;
    mem_addr  = pc_addr;
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - scoreboard testbench for fetch_seq with a bench-side PC and memory model
module tb_fetch_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] pc;
  logic       pc_inc;
  logic       pc_load;
  logic [7:0] pc_target;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic       mem_ready = 1'b0;
  logic [7:0] mem_rdata = 8'hEE;
  logic       ins_valid;
  logic       ins_ready;
  logic [7:0] ins_data;
  logic       halted;

  logic [7:0] mem [256];
  int         mem_lat;
  logic       mem_hold;
  int         wait_cnt = 0;
  logic       pc_set_en;
  logic [7:0] pc_set_val;

  int         chk_kind;
  logic [7:0] chk_val;
  logic       chk_rate;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;

  logic [7:0] exp_ins [$];
  logic [7:0] exp_addr [$];
  logic [7:0] exp_tgt [$];

  always #5 clk = ~clk;

  fetch_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .pc_addr   (pc),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready),
    .ins_data  (ins_data),
    .halted    (halted)
  );

  // Program counter owned by the bench: load beats inc, wraps naturally at 8 bits
  always @(posedge clk) begin
    if (pc_set_en)    pc <= pc_set_val;
    else if (pc_load) pc <= pc_target;
    else if (pc_inc)  pc <= pc + 8'd1;
  end

  // Program memory: answers a request after mem_lat wait cycles, drives junk otherwise
  always @(posedge clk) begin
    #1;
    if (mem_req === 1'b1 && !mem_hold && wait_cnt >= mem_lat) begin
      mem_ready = 1'b1;
      mem_rdata = mem[mem_addr];
      wait_cnt  = 0;
    end else begin
      mem_ready = 1'b0;
      mem_rdata = 8'hEE;
      if (mem_req === 1'b1) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  logic [7:0] e_v;
  logic       p_valid = 1'b0, p_ready = 1'b0, p_req = 1'b0, p_rdy = 1'b0;
  logic [7:0] p_data = 8'h00, p_addr = 8'h00;
  int         prev_acc = 0;
  logic       have_prev = 1'b0;

  // Monitor: pops scoreboard queues on DUT events and checks protocol rules
  always @(negedge clk) begin
    cyc++;
    if (ins_valid === 1'b1 && ins_ready === 1'b1) begin
      checks++;
      if (exp_ins.size() == 0) begin
        errors++;
        $display("FAIL ins_unexpected got=%h required=none", ins_data);
      end else begin
        e_v = exp_ins.pop_front();
        if (ins_data !== e_v) begin
          errors++;
          $display("FAIL ins_data got=%h required=%h", ins_data, e_v);
        end
      end
      if (chk_rate && have_prev) begin
        checks++;
        if (cyc - prev_acc != 3) begin
          errors++;
          $display("FAIL issue_rate got=%0d required=3", cyc - prev_acc);
        end
      end
      prev_acc  = cyc;
      have_prev = 1'b1;
    end
    if (ins_valid === 1'b1 && p_valid && !p_ready) begin
      checks++;
      if (ins_data !== p_data) begin
        errors++;
        $display("FAIL ins_hold got=%h required=%h", ins_data, p_data);
      end
    end
    if (ins_valid === 1'b1) begin
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL req_during_issue got=%b required=0", mem_req);
      end
    end
    if (mem_req === 1'b1 && p_req && !p_rdy) begin
      checks++;
      if (mem_addr !== p_addr) begin
        errors++;
        $display("FAIL addr_hold got=%h required=%h", mem_addr, p_addr);
      end
    end
    if (mem_req === 1'b1 && mem_ready) begin
      checks++;
      if (exp_addr.size() == 0) begin
        errors++;
        $display("FAIL fetch_unexpected got=%h required=none", mem_addr);
      end else begin
        e_v = exp_addr.pop_front();
        if (mem_addr !== e_v) begin
          errors++;
          $display("FAIL fetch_addr got=%h required=%h", mem_addr, e_v);
        end
      end
    end
    if (pc_inc === 1'b1 || pc_load === 1'b1) begin
      checks++;
      if ((pc_inc === 1'b1 && pc_load === 1'b1) || !mem_ready) begin
        errors++;
        $display("FAIL pc_ctrl got=inc%b/load%b/ready%b required=one_with_ready", pc_inc, pc_load, mem_ready);
      end
    end
    if (pc_load === 1'b1) begin
      checks++;
      if (exp_tgt.size() == 0) begin
        errors++;
        $display("FAIL load_unexpected got=%h required=none", pc_target);
      end else begin
        e_v = exp_tgt.pop_front();
        if (pc_target !== e_v) begin
          errors++;
          $display("FAIL pc_target got=%h required=%h", pc_target, e_v);
        end
      end
    end
    if (halted === 1'b1) begin
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL req_while_halted got=%b required=0", mem_req);
      end
    end
    case (chk_kind)
      1: begin
        checks++;
        if ({mem_req, ins_valid, pc_inc, pc_load, halted, pc_target, ins_data} !== 21'd0) begin
          errors++;
          $display("FAIL idle_outputs got=req%b val%b inc%b load%b halt%b tgt%h data%h required=all_zero",
                   mem_req, ins_valid, pc_inc, pc_load, halted, pc_target, ins_data);
        end
      end
      2: begin
        checks++;
        if (halted !== 1'b1 || mem_req !== 1'b0) begin
          errors++;
          $display("FAIL halted_state got=halt%b req%b required=halt1_req0", halted, mem_req);
        end
      end
      3: begin
        checks++;
        if (pc !== chk_val) begin
          errors++;
          $display("FAIL pc_value got=%h required=%h", pc, chk_val);
        end
      end
      4: begin
        checks++;
        if (exp_ins.size() + exp_addr.size() + exp_tgt.size() != 0) begin
          errors++;
          $display("FAIL scoreboard_left got=ins%0d/addr%0d/tgt%0d required=0/0/0",
                   exp_ins.size(), exp_addr.size(), exp_tgt.size());
        end
      end
      default: ;
    endcase
    p_valid = (ins_valid === 1'b1);
    p_ready = (ins_ready === 1'b1);
    p_data  = ins_data;
    p_req   = (mem_req === 1'b1);
    p_rdy   = mem_ready;
    p_addr  = mem_addr;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_set_en  = 1'b1;
    pc_set_val = v;
    tick();
    pc_set_en  = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check(input int kind, input logic [7:0] v);
    chk_kind = kind;
    chk_val  = v;
    tick();
    chk_kind = 0;
  endtask

  task automatic wait_halted(input int budget);
    for (int i = 0; i < budget && halted !== 1'b1; i++) tick();
    check(2, 8'h00);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ins_ready = 1'b1;
    mem_lat = 0; mem_hold = 1'b0; pc_set_en = 1'b0; pc_set_val = 8'h00;
    chk_kind = 0; chk_val = 8'h00; chk_rate = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(); tick();
    reset = 1'b0;
    check(1, 8'h00);

    // T1: two plain instructions then HALT, back-to-back rate
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'hFF;
    set_pc(8'h00);
    exp_addr.push_back(8'h00); exp_addr.push_back(8'h01); exp_addr.push_back(8'h02);
    exp_ins.push_back(8'h12);  exp_ins.push_back(8'h34);
    chk_rate = 1'b1;
    pulse_start();
    wait_halted(50);
    chk_rate = 1'b0;
    check(3, 8'h03);
    check(4, 8'h00);

    // T2: JMP to 0x80, instruction there, then HALT
    mem[8'h00] = 8'h40; mem[8'h01] = 8'h80; mem[8'h80] = 8'h07; mem[8'h81] = 8'hFF;
    set_pc(8'h00);
    exp_addr.push_back(8'h00); exp_addr.push_back(8'h01);
    exp_addr.push_back(8'h80); exp_addr.push_back(8'h81);
    exp_tgt.push_back(8'h80);
    exp_ins.push_back(8'h07);
    pulse_start();
    wait_halted(50);
    check(3, 8'h82);
    check(4, 8'h00);

    // T3: memory answers after 3 wait cycles
    mem[8'h20] = 8'h33; mem[8'h21] = 8'hFF;
    set_pc(8'h20);
    mem_lat = 3;
    exp_addr.push_back(8'h20); exp_addr.push_back(8'h21);
    exp_ins.push_back(8'h33);
    pulse_start();
    wait_halted(100);
    mem_lat = 0;
    check(3, 8'h22);
    check(4, 8'h00);

    // T4: execute stage stalls 4 cycles; a stray start during the stall is ignored
    mem[8'h30] = 8'h44; mem[8'h31] = 8'hFF;
    set_pc(8'h30);
    ins_ready = 1'b0;
    exp_addr.push_back(8'h30); exp_addr.push_back(8'h31);
    exp_ins.push_back(8'h44);
    pulse_start();
    for (int i = 0; i < 20 && ins_valid !== 1'b1; i++) tick();
    tick(); tick();
    pulse_start();
    tick();
    ins_ready = 1'b1;
    wait_halted(50);
    check(3, 8'h32);
    check(4, 8'h00);

    // T5: HALT at 0x05, restart resumes at 0x06
    mem[8'h05] = 8'hFF; mem[8'h06] = 8'h55; mem[8'h07] = 8'hFF;
    set_pc(8'h05);
    exp_addr.push_back(8'h05);
    pulse_start();
    wait_halted(50);
    check(3, 8'h06);
    exp_addr.push_back(8'h06); exp_addr.push_back(8'h07);
    exp_ins.push_back(8'h55);
    pulse_start();
    wait_halted(50);
    check(3, 8'h08);
    check(4, 8'h00);

    // T6a: instruction at 0xFF, PC wraps to 0x00
    mem[8'hFF] = 8'h21; mem[8'h00] = 8'hFF;
    set_pc(8'hFF);
    exp_addr.push_back(8'hFF); exp_addr.push_back(8'h00);
    exp_ins.push_back(8'h21);
    pulse_start();
    wait_halted(50);
    check(3, 8'h01);
    check(4, 8'h00);

    // T6b: reset while the JMP operand read is outstanding
    mem[8'h10] = 8'h40;
    set_pc(8'h10);
    exp_addr.push_back(8'h10);
    pulse_start();
    tick();
    mem_hold = 1'b1;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check(1, 8'h00);
    mem_hold = 1'b0;
    check(4, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
